prog_delay_line: RTL and testbench

- Multi-bit delay line whose delay is programmable at run time, from 0 to MAX_DELAY clock-enabled ticks.
- Successor to the fixed-delay shift-register lines: storage is a circular buffer with a write pointer, not a DELAY-deep shift register per bit.
- Tracks how much valid history it holds, so the output is zero until enough samples have been written.
- Used where pulse-timing alignment delays must be tuned without resynthesis.

---
 rtl/delay_line_pkg.sv | 15 +
 rtl/delay_line_ram.sv | 24 ++
 rtl/prog_delay_line.sv | 87 ++++++++
 tb/tb_prog_delay_line.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the programmable delay line.
package delay_line_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} fill_state_t;

  function automatic int clamp_delay(input int value, input int max_d);
    return (value > max_d) ? max_d : value;
  endfunction

  // Modulo-depth subtract; d may equal depth, which lands back on wp.
  function automatic int ptr_sub(input int wp, input int d, input int depth);
    return (wp >= d) ? wp - d : wp + depth - d;
  endfunction

endpackage

// File: rtl/delay_line_ram.sv
// Sample history store: one synchronous write port, one combinational read port.
module delay_line_ram #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: stale contents are masked by the fill counter upstream.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_delay_line.sv
// Run-time programmable delay line over a circular buffer.
// Optional macro PROG_DELAY_LINE_FLUSH_EN: a delay change discards history.
module prog_delay_line
  import delay_line_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int MAX_DELAY     = 512,
  parameter int DEFAULT_DELAY = 300,
  localparam int DW           = $clog2(MAX_DELAY + 1)
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             clock_ena,
  input  logic [WIDTH-1:0] sig_in,
  input  logic [DW-1:0]    delay_in,
  input  logic             delay_load,
  output logic [WIDTH-1:0] sig_out,
  output logic [DW-1:0]    delay_cur,
  output logic             primed
);

  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DW-1:0] MAX_D   = DW'(MAX_DELAY);
  localparam logic [DW-1:0] DEF_D   = DW'(DEFAULT_DELAY);
  localparam logic [AW-1:0] LAST_WP = AW'(MAX_DELAY - 1);

  logic [AW-1:0]    wp, ra;
  logic [DW-1:0]    fill_cnt, fill_nxt, dly_req;
  logic [WIDTH-1:0] rdata;
  logic             dly_hit;
  fill_state_t      state, state_nxt;

  assign dly_req = DW'(clamp_delay(int'(delay_in), MAX_DELAY));
  assign ra      = AW'(ptr_sub(int'(wp), int'(delay_cur), MAX_DELAY));
  assign dly_hit = (delay_cur == '0) || (fill_cnt >= delay_cur);

  delay_line_ram #(.WIDTH(WIDTH), .DEPTH(MAX_DELAY), .AW(AW)) u_ram (
    .clock (clock),
    .we    (clock_ena & ~sclr),
    .waddr (wp),
    .wdata (sig_in),
    .raddr (ra),
    .rdata (rdata)
  );

  always_comb begin
    fill_nxt  = fill_cnt;
    state_nxt = state;
    if (clock_ena && fill_cnt != MAX_D) fill_nxt = fill_cnt + DW'(1);
`ifdef PROG_DELAY_LINE_FLUSH_EN
    // Only a real change of delay flushes; reloading the same value is seamless.
    if (delay_load && dly_req != delay_cur) fill_nxt = clock_ena ? DW'(1) : '0;
`endif
    case (state)
      EMPTY:   if (fill_nxt != '0) state_nxt = (fill_nxt == MAX_D) ? FULL : FILLING;
      FILLING: if (fill_nxt == MAX_D) state_nxt = FULL;
               else if (fill_nxt == '0) state_nxt = EMPTY;
      FULL:    if (fill_nxt != MAX_D) state_nxt = (fill_nxt == '0) ? EMPTY : FILLING;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      wp        <= '0;
      fill_cnt  <= '0;
      state     <= EMPTY;
      delay_cur <= DEF_D;
    end else begin
      if (clock_ena) wp <= (wp == LAST_WP) ? '0 : wp + AW'(1);
      fill_cnt <= fill_nxt;
      state    <= state_nxt;
      if (delay_load) delay_cur <= dly_req;
    end
  end

  always_comb begin
    sig_out = '0;
    if (!sclr) begin
      if (delay_cur == '0) sig_out = sig_in;
      else if (dly_hit)    sig_out = rdata;
    end
  end

  assign primed = !sclr && dly_hit;

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line (WIDTH=3, MAX_DELAY=8, DEFAULT_DELAY=4).
module tb_prog_delay_line;

  localparam int W = 3, MAXD = 8, DEFD = 4, DW = 4;

  typedef struct packed {
    logic [W-1:0]  sig;
    logic          prm;
    logic [DW-1:0] dly;
  } exp_t;

  logic          clock = 0, sclr = 0, clock_ena = 0, delay_load = 0;
  logic [W-1:0]  sig_in = '0, sig_out;
  logic [DW-1:0] delay_in = '0, delay_cur;
  logic          primed;

  int checks = 0, passed = 0;
  exp_t exp_q[$];
  // Reference model: full history of written samples plus a fill count.
  logic [W-1:0] hist[$];
  int m_fill = 0, m_dly = DEFD;

  prog_delay_line #(.WIDTH(W), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)) dut (
    .clock(clock), .sclr(sclr), .clock_ena(clock_ena), .sig_in(sig_in),
    .delay_in(delay_in), .delay_load(delay_load),
    .sig_out(sig_out), .delay_cur(delay_cur), .primed(primed)
  );

  always #5 clock = ~clock;

  task automatic step(input string name, input logic rst, input logic ena,
                      input int din, input logic ld, input int dly);
    exp_t e, got;
    int newd;
    bit changed;
    @(negedge clock);
    sclr = rst; clock_ena = ena; sig_in = W'(din); delay_load = ld; delay_in = DW'(dly);
    @(posedge clock);
    if (rst) begin
      hist.delete(); m_fill = 0; m_dly = DEFD;
    end else begin
      newd = ld ? ((dly > MAXD) ? MAXD : dly) : m_dly;
      changed = ld && (newd != m_dly);
      if (ena) begin
        hist.push_back(W'(din));
        m_fill = (m_fill + 1 > MAXD) ? MAXD : m_fill + 1;
      end
`ifdef PROG_DELAY_LINE_FLUSH_EN
      if (changed) m_fill = ena ? 1 : 0;
`else
      if (changed) m_fill = m_fill;
`endif
      m_dly = newd;
    end
    e.dly = DW'(m_dly);
    if (rst) begin
      e.sig = '0; e.prm = 1'b0;
    end else if (m_dly == 0) begin
      e.sig = W'(din); e.prm = 1'b1;
    end else if (m_fill >= m_dly) begin
      e.sig = hist[hist.size() - m_dly]; e.prm = 1'b1;
    end else begin
      e.sig = '0; e.prm = 1'b0;
    end
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    got = '{sig: sig_out, prm: primed, dly: delay_cur};
    checks++;
    if (got !== e)
      $display("FAIL %s: sig_out=%0d primed=%0b delay_cur=%0d, expected sig_out=%0d primed=%0b delay_cur=%0d",
               name, got.sig, got.prm, got.dly, e.sig, e.prm, e.dly);
    else passed++;
  endtask

  task automatic test_reset();
    step("reset", 1, 0, 0, 0, 0);
    step("reset_hold", 1, 1, 3, 0, 0);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 7; i++) step("fill", 0, 1, i, 0, 0);
  endtask

  task automatic test_passthrough();
    step("pass_load0", 0, 1, 5, 1, 0);
    for (int i = 0; i < 3; i++) step("pass", 0, 1, 2 + i, 0, 0);
  endtask

  task automatic test_clamp_wrap();
    step("clamp_load12", 0, 1, 6, 1, 12);
    for (int k = 1; k <= 20; k++) step("max_delay_wrap", 0, 1, k * 3, 0, 0);
  endtask

  task automatic test_enable();
    step("ena_load4", 0, 1, 1, 1, 4);
    for (int i = 0; i < 4; i++) step("ena_steady", 0, 1, i + 4, 0, 0);
    step("ena_on", 0, 1, 7, 0, 0);
    step("ena_off1", 0, 0, 2, 0, 0);
    step("ena_off2", 0, 0, 5, 0, 0);
    step("ena_resume", 0, 1, 6, 0, 0);
    step("ena_after", 0, 1, 3, 0, 0);
  endtask

  task automatic test_reset_load();
    step("rst_and_load", 1, 1, 4, 1, 2);
    for (int i = 1; i <= 6; i++) step("refill", 0, 1, i, 0, 0);
  endtask

  task automatic test_grow();
    step("grow_rst", 1, 0, 0, 0, 0);
    step("grow_load2", 0, 1, 1, 1, 2);
    for (int i = 2; i <= 10; i++) step("grow_pre", 0, 1, i, 0, 0);
    step("grow_load6", 0, 1, 11, 1, 6);
    for (int i = 12; i <= 20; i++) step("grow_post", 0, 1, i, 0, 0);
    step("shrink_load3", 0, 1, 21, 1, 3);
    step("shrink_post", 0, 1, 22, 0, 0);
    step("same_reload", 0, 1, 23, 1, 3);
    step("same_post", 0, 1, 24, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      step("random", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)));
  endtask

  initial begin
    test_reset();
    test_fill();
    test_passthrough();
    test_clamp_wrap();
    test_enable();
    test_reset_load();
    test_grow();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
